prime_check: RTL

- Trial-division primality tester; the sequencing stage that drives the divmod block and consumes its quotient/remainder results.
- Accepts a candidate N on a go pulse.
- Issues successive N / d divisions to an external divmod instance, d = 2, 3, 4, ...
- Reports prime/composite plus the smallest factor; sits between the candidate generator and divmod in the primogen datapath.

---
 rtl/prime_check.sv | 119 +++++++++++
 1 files changed

// File: rtl/prime_check.sv
// Trial-division primality tester that sequences N/d divisions through an external divmod.
// Optional per-run division counter enabled by defining PRIME_CHECK_STATS_EN.
module prime_check #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] n,
  output logic             ready,
  output logic             is_prime,
  output logic [WIDTH-1:0] factor,
  output logic             error,
  output logic             dm_go,
  output logic [WIDTH-1:0] dm_a,
  output logic [WIDTH-1:0] dm_b,
  input  logic             dm_ready,
  input  logic             dm_error,
  input  logic [WIDTH-1:0] dm_div,
  input  logic [WIDTH-1:0] dm_mod
`ifdef PRIME_CHECK_STATS_EN
  ,
  output logic [WIDTH-1:0] div_count
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    GAP,
    WAIT,
    EVAL,
    DONE
  } state_t;

  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t state;

  // dm_a doubles as the latched candidate N and dm_b as the trial divisor d.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ready    <= 1'b1;
      is_prime <= 1'b0;
      factor   <= '0;
      error    <= 1'b0;
      dm_go    <= 1'b0;
      dm_a     <= '0;
      dm_b     <= '0;
    end else begin
      dm_go <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            dm_a     <= n;
            error    <= 1'b0;
            factor   <= '0;
            is_prime <= 1'b0;
            ready    <= 1'b0;
            if (n < TWO) begin
              state <= DONE;
            end else begin
              dm_b  <= TWO;
              dm_go <= 1'b1;
              state <= ISSUE;
            end
          end
        end
        ISSUE: state <= GAP;
        // divmod drops ready only after sampling go, so skip one cycle before watching it
        GAP:   state <= WAIT;
        WAIT: begin
          if (dm_ready) state <= EVAL;
        end
        EVAL: begin
          if (dm_error) begin
            error    <= 1'b1;
            is_prime <= 1'b0;
            factor   <= '0;
            state    <= DONE;
          end else if (dm_div < dm_b) begin
            is_prime <= 1'b1;
            factor   <= '0;
            state    <= DONE;
          end else if (dm_mod == '0) begin
            is_prime <= 1'b0;
            factor   <= dm_b;
            state    <= DONE;
          end else begin
            dm_b  <= dm_b + ONE;
            dm_go <= 1'b1;
            state <= ISSUE;
          end
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PRIME_CHECK_STATS_EN
  // One ISSUE cycle per dm_go pulse, so counting ISSUE cycles counts divisions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_count <= '0;
    end else if (state == IDLE && go) begin
      div_count <= '0;
    end else if (state == ISSUE) begin
      div_count <= div_count + ONE;
    end
  end
`endif

endmodule
